// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared state encoding and opcode constants for the fetch PC unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [5:0] c_halt_opcode_dflt = 6'h3F;
    localparam int         c_opc_msb          = 31;
    localparam int         c_opc_lsb          = 26;

endpackage

`default_nettype wire

// File: rtl/pc_next_sel.sv
// ============================================================================
// Module   : pc_next_sel
// Purpose  : Combinational next-PC priority mux: halt, stall, jump, branch, +1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_next_sel
    import fetch_pkg::*;
#(
    parameter logic [5:0] HALT_OPCODE = c_halt_opcode_dflt
) (
    input  logic [31:0] pc,
    input  logic [5:0]  opcode,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] next_pc,
    output logic        halt_hit
);

    always_comb begin
        // A stalled halt instruction is not yet committed, so it cannot halt.
        halt_hit = (opcode == HALT_OPCODE) && !stall;
        next_pc  = pc + 32'd1;
        if (halt_hit || stall) begin
            next_pc = pc;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// Module   : fetch_pc_unit
// Purpose  : Fetch program counter with BOOT/RUN/HALTED control; optional
//            performance counters enabled by FETCH_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h00000000,
    parameter logic [5:0]  HALT_OPCODE = c_halt_opcode_dflt
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        resume,
    output logic [31:0] address,
    output logic [31:0] pc_plus1,
    output logic        valid,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] insn_count
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  w_sel_pc;
    logic         w_halt_hit;
    logic [31:0]  w_pc_plus1;

    // Only the opcode field steers the fetch unit.
    logic w_unused_insn;
    assign w_unused_insn = ^instruction[c_opc_lsb-1:0];

    pc_next_sel #(
        .HALT_OPCODE   (HALT_OPCODE)
    ) u_pc_next_sel (
        .pc            (r_pc),
        .opcode        (instruction[c_opc_msb:c_opc_lsb]),
        .stall         (stall),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (w_sel_pc),
        .halt_hit      (w_halt_hit)
    );

    assign w_pc_plus1 = r_pc + 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                w_pc_nxt = w_sel_pc;
                if (w_halt_hit) begin
                    w_state_nxt = HALTED;
                end
            end
            HALTED: begin
                if (resume) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = w_pc_plus1;
                end
            end
            default: begin
                w_state_nxt = BOOT;
                w_pc_nxt    = RESET_PC;
            end
        endcase
    end

    assign address  = r_pc;
    assign pc_plus1 = w_pc_plus1;
    assign valid    = (r_state == RUN);
    assign halted   = (r_state == HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_insn_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_cnt <= 32'd0;
            r_insn_cnt  <= 32'd0;
        end else if (r_state == RUN) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (!stall && !w_halt_hit) begin
                r_insn_cnt <= r_insn_cnt + 32'd1;
            end
        end
    end

    assign cycle_count = r_cycle_cnt;
    assign insn_count  = r_insn_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: word address loaded into the PC on reset.
REQ-002 Parameter HALT_OPCODE, default 6'h3F: value of instruction[31:26] that marks a halt.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst==0 resets immediately, independent of clk.
REQ-005 instruction  input  32  word returned by instruction memory for the current address.
REQ-006 stall  input  1  hold PC this cycle.
REQ-007 branch_taken  input  1  redirect PC to branch_target.
REQ-008 branch_target  input  32  branch destination, word address.
REQ-009 jump  input  1  redirect PC to jump_target.
REQ-010 jump_target  input  32  jump destination, word address.
REQ-011 resume  input  1  single-cycle pulse that leaves the halted state.
REQ-012 address  output  32  current PC, driven to instruction memory.
REQ-013 pc_plus1  output  32  address+1, combinational, for link and sequential use.
REQ-014 valid  output  1  high when instruction corresponds to address and may be executed.
REQ-015 halted  output  1  high while in HALTED.

Function
REQ-016 States: BOOT, RUN, HALTED, 2-bit encoded.
REQ-017 Transitions:
- BOOT -> RUN after exactly one clk edge following rst release.
- BOOT exists because memory contents are loaded during reset.
- In BOOT: address holds RESET_PC and valid=0.
REQ-018 RUN, per rising edge, first matching rule applies:
- Halt: instruction[31:26]==HALT_OPCODE and stall==0 -> go to HALTED; PC holds.
- Stall: stall==1 -> PC holds.
- Jump: jump==1 -> PC=jump_target.
- Branch: branch_taken==1 -> PC=branch_target.
- Otherwise: PC=PC+1.
REQ-019 Jump and branch_taken both high: jump wins.
- Redirect inputs are ignored when halt is detected in the same cycle.
REQ-020 PC arithmetic is 32-bit modulo.
- 32'hFFFFFFFF+1 wraps to 32'h00000000.
- No error flag is raised on wrap.
REQ-021 valid=1 in RUN, 0 in BOOT and HALTED; valid is combinational from state.
REQ-022 HALTED: PC frozen at the halt instruction's address, halted=1.
- stall, jump and branch_taken are ignored.
REQ-023 resume=1 in HALTED -> RUN, PC=PC+1 on that edge.
- resume is ignored in BOOT and RUN.
REQ-024 Outputs change only on clk edges or rst assertion.
- pc_plus1 and valid are derived combinationally from registered state.

Reset
REQ-025 While rst==0: state=BOOT, address=RESET_PC, valid=0, halted=0.
- Applies immediately, without waiting for a clk edge.
REQ-026 rst asserted in any state, including mid-stall or HALTED, aborts that operation.
- All pending redirects are discarded.
REQ-027 After rst deasserts, the first rising edge moves BOOT -> RUN.
- address stays RESET_PC on that edge.

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN defined:
- Add outputs cycle_count[31:0] and insn_count[31:0].
- cycle_count increments on every clk edge in RUN.
- insn_count increments on every RUN edge with stall==0 and no halt detected.
- Both counters reset to 0 with rst and hold in HALTED.
- Both counters wrap at 2^32.
REQ-029 Macro not defined: the counters and their ports are absent, and all other behaviour is identical.

Structure
REQ-030 Shared package fetch_pkg holds:
- State encoding constants: BOOT=2'd0, RUN=2'd1, HALTED=2'd2.
- HALT_OPCODE default value.
- Opcode field bounds [31:26].
REQ-031 One sub-module, pc_next_sel: a combinational next-PC priority mux implementing REQ-018/019.
- All registers stay in fetch_pc_unit.

Verification
REQ-032 Reset/boot:
- Stimulus: rst low 3 cycles, then high; instructions non-halt.
- Response: address=0 and valid=0 through the first edge after release; then address 1, 2, 3 on successive edges.
REQ-033 Redirect priority:
- Stimulus: in RUN at PC=5, jump=1 with jump_target=32'h40, and branch_taken=1 with branch_target=32'h80, in the same cycle.
- Response: next PC=32'h40.
- Then: branch alone with target 32'h80 -> PC=32'h80.
REQ-034 Stall:
- Stimulus: at PC=7, stall=1 for 2 cycles with jump=1.
- Response: PC stays 7 and valid stays 1.
- Then: stall=0, no redirect -> PC=8.
REQ-035 Halt/resume:
- Stimulus: instruction=32'hFC000000 at PC=12.
- Response: halted=1 and valid=0 after the edge, with PC=12.
- Then: jump ignored; resume pulse -> PC=13, halted=0.
- Then: halt presented with stall=1 -> no halt.
REQ-036 Wrap and async reset:
- Stimulus: branch to 32'hFFFFFFFF.
- Response: next PC=0.
- Then: assert rst mid-cycle while in HALTED -> address=RESET_PC and halted=0 before the next edge.
- Then, with FETCH_PERF_CNT_EN defined: cycle_count and insn_count read 0.
